spi_byte_shifter: RTL and testbench



---
 rtl/spi_byte_shifter.sv | 88 ++++++++
 tb/tb_spi_byte_shifter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: byte-level SPI receive/transmit shift engine (SCL edge strobes in, serial words out).
// Define SPI_LSB_FIRST_EN to shift both paths LSB first; the default build is MSB first.
module spi_byte_shifter #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rx_en_i,
    input  logic                  miso_i,
    input  logic                  scl_pos_edge_detected_i,
    output logic                  data_ack_o,
    output logic [WORD_WIDTH-1:0] rx_data_o,
    input  logic                  tx_en_i,
    input  logic                  scl_neg_edge_detected_i,
    input  logic [WORD_WIDTH-1:0] tx_data_i,
    output logic                  mosi_o
);

    localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    // The receive register only needs W-1 bits: the final bit goes straight into rx_data_o.
    logic [WORD_WIDTH-2:0] rx_sr;
    logic [WORD_WIDTH-1:0] rx_word;
    logic [CNT_W-1:0]      rx_cnt;

    logic [WORD_WIDTH-1:0] tx_sr;
    logic [WORD_WIDTH-1:0] tx_sr_shifted;
    logic [CNT_W-1:0]      tx_cnt;

`ifdef SPI_LSB_FIRST_EN
    assign rx_word       = {miso_i, rx_sr};
    assign tx_sr_shifted = {1'b0, tx_sr[WORD_WIDTH-1:1]};
    assign mosi_o        = tx_en_i & tx_sr[0];
`else
    assign rx_word       = {rx_sr, miso_i};
    assign tx_sr_shifted = {tx_sr[WORD_WIDTH-2:0], 1'b0};
    assign mosi_o        = tx_en_i & tx_sr[WORD_WIDTH-1];
`endif

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_sr      <= '0;
            rx_cnt     <= '0;
            rx_data_o  <= '0;
            data_ack_o <= 1'b0;
        end else begin
            data_ack_o <= 1'b0;
            if (!rx_en_i) begin
                rx_cnt <= '0;
            end else if (scl_pos_edge_detected_i) begin
`ifdef SPI_LSB_FIRST_EN
                rx_sr <= rx_word[WORD_WIDTH-1:1];
`else
                rx_sr <= rx_word[WORD_WIDTH-2:0];
`endif
                if (rx_cnt == LAST_BIT) begin
                    rx_data_o  <= rx_word;
                    data_ack_o <= 1'b1;
                    rx_cnt     <= '0;
                end else begin
                    rx_cnt <= rx_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Idle transmit keeps reloading so the first bit is on mosi_o as soon as tx_en_i rises.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else if (!tx_en_i) begin
            tx_sr  <= tx_data_i;
            tx_cnt <= '0;
        end else if (scl_neg_edge_detected_i) begin
            if (tx_cnt == LAST_BIT) begin
                tx_sr  <= tx_data_i;
                tx_cnt <= '0;
            end else begin
                tx_sr  <= tx_sr_shifted;
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// tb_spi_byte_shifter: directed and randomized checks of spi_byte_shifter against a bit-position model.
// Honours SPI_LSB_FIRST_EN the same way as the design so either build can be exercised.
module tb_spi_byte_shifter;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       rx_en_i;
    logic       miso_i;
    logic       scl_pos_edge_detected_i;
    logic       data_ack_o;
    logic [7:0] rx_data_o;
    logic       tx_en_i;
    logic       scl_neg_edge_detected_i;
    logic [7:0] tx_data_i;
    logic       mosi_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word-level view of what has been received/sent so far.
    int         m_rx_cnt;
    logic [7:0] m_rx_acc;
    logic [7:0] m_rx_data;
    logic       m_ack;
    int         m_tx_idx;
    logic [7:0] m_tx_word;

    spi_byte_shifter #(.WORD_WIDTH(8)) dut (
        .clk_i                   (clk_i),
        .reset_i                 (reset_i),
        .rx_en_i                 (rx_en_i),
        .miso_i                  (miso_i),
        .scl_pos_edge_detected_i (scl_pos_edge_detected_i),
        .data_ack_o              (data_ack_o),
        .rx_data_o               (rx_data_o),
        .tx_en_i                 (tx_en_i),
        .scl_neg_edge_detected_i (scl_neg_edge_detected_i),
        .tx_data_i               (tx_data_i),
        .mosi_o                  (mosi_o)
    );

    always #5 clk_i = ~clk_i;

    // Bit position within the word of the k-th bit on the wire.
    function automatic int bit_pos(input int k);
`ifdef SPI_LSB_FIRST_EN
        return k;
`else
        return 7 - k;
`endif
    endfunction

    function automatic logic serial_bit(input logic [7:0] w, input int k);
        logic [7:0] t;
        t = w >> bit_pos(k);
        return t[0];
    endfunction

    function automatic logic exp_mosi();
        return tx_en_i ? serial_bit(m_tx_word, m_tx_idx) : 1'b0;
    endfunction

    // Drive one clock of inputs, advance the model, and return #1 after the edge.
    task automatic cyc(input logic ren, input logic pos, input logic mi,
                       input logic ten, input logic neg, input logic [7:0] txd);
        rx_en_i                 = ren;
        scl_pos_edge_detected_i = pos;
        miso_i                  = mi;
        tx_en_i                 = ten;
        scl_neg_edge_detected_i = neg;
        tx_data_i               = txd;
        m_ack = 1'b0;
        if (!ren) begin
            m_rx_cnt = 0;
            m_rx_acc = 8'h00;
        end else if (pos) begin
            m_rx_acc = m_rx_acc + (8'(mi) << bit_pos(m_rx_cnt));
            m_rx_cnt++;
            if (m_rx_cnt == 8) begin
                m_rx_data = m_rx_acc;
                m_ack     = 1'b1;
                m_rx_cnt  = 0;
                m_rx_acc  = 8'h00;
            end
        end
        if (!ten) begin
            m_tx_word = txd;
            m_tx_idx  = 0;
        end else if (neg) begin
            if (m_tx_idx == 7) begin
                m_tx_word = txd;
                m_tx_idx  = 0;
            end else begin
                m_tx_idx++;
            end
        end
        @(posedge clk_i);
        #1;
        scl_pos_edge_detected_i = 1'b0;
        scl_neg_edge_detected_i = 1'b0;
    endtask

    // Reset with strobes asserted; enables keep their current values.
    task automatic apply_reset();
        reset_i                 = 1'b1;
        scl_pos_edge_detected_i = 1'b1;
        scl_neg_edge_detected_i = 1'b1;
        miso_i                  = 1'b1;
        m_rx_cnt  = 0;
        m_rx_acc  = 8'h00;
        m_rx_data = 8'h00;
        m_ack     = 1'b0;
        m_tx_idx  = 0;
        m_tx_word = 8'h00;
        @(posedge clk_i);
        #1;
        reset_i                 = 1'b0;
        scl_pos_edge_detected_i = 1'b0;
        scl_neg_edge_detected_i = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        apply_reset();
        n_checks++;
        if (rx_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %0h expected 00", rx_data_o);
        end
        n_checks++;
        if (data_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack: got %0b expected 0", data_ack_o);
        end
        n_checks++;
        if (mosi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mosi: got %0b expected 0", mosi_o);
        end
        // Both counters restarted: ack and the reload land on exactly the 8th strobe.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
            n_checks++;
            if (data_ack_o !== (k == 7)) begin
                n_fail++;
                $display("FAIL reset_rx_count[%0d]: ack got %0b expected %0b", k, data_ack_o, (k == 7));
            end
            n_checks++;
            if (mosi_o !== (k == 7)) begin
                n_fail++;
                $display("FAIL reset_tx_count[%0d]: mosi got %0b expected %0b", k, mosi_o, (k == 7));
            end
        end
        n_checks++;
        if (rx_data_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_first_word: got %0h expected ff", rx_data_o);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_rx_words(input string name, input logic [7:0] w0, input logic [7:0] w1,
                                 input int n_words);
        logic [7:0] words [2];
        words[0] = w0;
        words[1] = w1;
        for (int n = 0; n < n_words; n++) begin
            for (int k = 0; k < 8; k++) begin
                cyc(1'b1, 1'b1, serial_bit(words[n], k), 1'b0, 1'b0, 8'h00);
                n_checks++;
                if (data_ack_o !== (k == 7)) begin
                    n_fail++;
                    $display("FAIL %s_ack[%0d.%0d]: got %0b expected %0b", name, n, k, data_ack_o, (k == 7));
                end
                if (k != 7) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            end
            n_checks++;
            if (rx_data_o !== words[n]) begin
                n_fail++;
                $display("FAIL %s_data[%0d]: got %0h expected %0h", name, n, rx_data_o, words[n]);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (data_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ack_width: got %0b expected 0", name, data_ack_o);
        end
    endtask

    task automatic test_rx_abort();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (data_ack_o !== 1'b0 || rx_data_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL abort_hold: ack %0b data %0h expected ack 0 data ff", data_ack_o, rx_data_o);
        end
        test_rx_words("abort", 8'h81, 8'h00, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_tx();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
        n_checks++;
        if (mosi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_idle: got %0b expected 0", mosi_o);
        end
        tx_en_i = 1'b1;
        #1;
        n_checks++;
        if (mosi_o !== serial_bit(8'hC3, 0)) begin
            n_fail++;
            $display("FAIL tx_first_bit: got %0b expected %0b", mosi_o, serial_bit(8'hC3, 0));
        end
        for (int k = 1; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (k >= 4) ? 8'h5A : 8'hC3);
            n_checks++;
            if (mosi_o !== serial_bit(8'hC3, k)) begin
                n_fail++;
                $display("FAIL tx_c3[%0d]: got %0b expected %0b", k, mosi_o, serial_bit(8'hC3, k));
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
        n_checks++;
        if (mosi_o !== serial_bit(8'h5A, 0)) begin
            n_fail++;
            $display("FAIL tx_reload: got %0b expected %0b", mosi_o, serial_bit(8'h5A, 0));
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (mosi_o !== serial_bit(8'h5A, 0)) begin
            n_fail++;
            $display("FAIL tx_no_strobe_hold: got %0b expected %0b", mosi_o, serial_bit(8'h5A, 0));
        end
        for (int k = 1; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
            n_checks++;
            if (mosi_o !== serial_bit(8'h5A, k)) begin
                n_fail++;
                $display("FAIL tx_5a[%0d]: got %0b expected %0b", k, mosi_o, serial_bit(8'h5A, k));
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_disabled();
        logic [7:0] held;
        held = rx_data_o;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            n_checks++;
            if (data_ack_o !== 1'b0 || rx_data_o !== held || mosi_o !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled[%0d]: ack %0b data %0h mosi %0b expected 0 %0h 0",
                         k, data_ack_o, rx_data_o, mosi_o, held);
            end
        end
    endtask

    // Both paths together with independent random strobes, enables and data.
    task automatic test_random();
        int acks = 0;
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
            if (m_ack) acks++;
            n_checks++;
            if (data_ack_o !== m_ack || rx_data_o !== m_rx_data || mosi_o !== exp_mosi()) begin
                n_fail++;
                $display("FAIL random[%0d]: ack %0b data %0h mosi %0b expected %0b %0h %0b",
                         k, data_ack_o, rx_data_o, mosi_o, m_ack, m_rx_data, exp_mosi());
            end
        end
        n_checks++;
        if (acks < 5) begin
            n_fail++;
            $display("FAIL random_activity: got %0d words expected at least 5", acks);
        end
    endtask

    initial begin
        rx_en_i   = 1'b0;
        tx_en_i   = 1'b0;
        tx_data_i = 8'h00;
        apply_reset();
        test_reset();
        test_rx_words("rx_a5", 8'hA5, 8'h00, 1);
        test_rx_words("back_to_back", 8'h3C, 8'hFF, 2);
        test_rx_abort();
        test_tx();
        test_disabled();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
